// File: rtl/shift_serializer.sv
// shift_serializer: parallel-in, serial-out transmitter.
// Words arrive on a valid/ready handshake and leave MSB first on dout, with
// each bit held for CLKS_PER_BIT cycles. A new word may be accepted in the
// final cycle of the current one, so consecutive words need no idle gap.
//
// Handshake: a word transfers on a rising edge where din_valid & din_ready
// are both 1. din_ready is a function of state, counters and rst only, never
// of din_valid. The serial side has no ready: once a frame starts, it runs
// to completion unless rst aborts it.
module shift_serializer #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din_data,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         dout_last,
  output logic         busy
);

  localparam int BW = $clog2(N);
  localparam int HW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CLKS_PER_BIT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [N-1:0]    shreg, shreg_n;
  logic [BW-1:0]   bit_cnt, bit_cnt_n;
  logic [HW-1:0]   hold_cnt, hold_cnt_n;

  logic            final_cyc;
  logic            xfer;

  // Last cycle of bit 0 of the current word.
  assign final_cyc = (state == SHIFT) && (bit_cnt == BIT_LAST) && (hold_cnt == HOLD_LAST);

  // Ready in IDLE or in the final cycle of a word; forced low during reset.
  assign din_ready = !rst && ((state == IDLE) || final_cyc);
  assign xfer      = din_valid && din_ready;

  // Serial outputs come only from registered state.
  assign busy       = (state == SHIFT);
  assign dout_valid = (state == SHIFT);
  assign dout       = (state == SHIFT) ? shreg[N-1] : 1'b0;
  assign dout_last  = final_cyc;

  // State, shift register and counters; rst overrides any same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  // Next-state: load on transfer, hold each bit, shift at hold wrap, and
  // either reload or return to IDLE at the end of the word.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    hold_cnt_n = hold_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_n    = SHIFT;
          shreg_n    = din_data;
          bit_cnt_n  = '0;
          hold_cnt_n = '0;
        end
      end
      SHIFT: begin
        if (final_cyc) begin
          bit_cnt_n  = '0;
          hold_cnt_n = '0;
          if (xfer) begin
            shreg_n = din_data;
          end else begin
            state_n = IDLE;
            shreg_n = '0;
          end
        end else if (hold_cnt == HOLD_LAST) begin
          hold_cnt_n = '0;
          bit_cnt_n  = bit_cnt + 1'b1;
          shreg_n    = {shreg[N-2:0], 1'b0};
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/shift_serializer.md
# shift_serializer

Parallel-in, serial-out transmitter that converts N-bit words into an MSB-first bitstream. A valid/ready handshake on the parallel side feeds the block, and a valid/last framed serial output drives downstream serial-in shift-register receivers. Any receiver that shifts each arriving bit into bit 0 ends up holding the original word after N bits, because the first bit sent is the MSB. The block supports back-to-back words with no idle gap, and a per-bit hold time for slower serial consumers.

## Interface

Parameters:
- N, default 8: word width in bits; legal range N >= 2.
- CLKS_PER_BIT, default 1: clock cycles each serial bit is held; legal range >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- din_data  input  N  parallel word to transmit.
- din_valid  input  1  din_data is valid.
- din_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial data bit; 0 when dout_valid = 0.
- dout_valid  output  1  dout carries a frame bit.
- dout_last  output  1  final cycle of the final bit (bit 0) of a word.
- busy  output  1  a word is being shifted out (state SHIFT).

## Operation

- Reset: state IDLE; shift register, bit counter and hold counter all 0. Outputs are din_ready 0, dout 0, dout_valid 0, dout_last 0, busy 0. While rst is high, din_ready is forced to 0.
- Handshake: a word transfers on a rising edge where din_valid & din_ready = 1.
  - din_ready depends only on state and counters, never on din_valid.
  - din_data is sampled only at a transfer; changes to it at any other time are ignored.
- State IDLE:
  - din_ready = 1.
  - On a transfer: load din_data into the shift register, clear both counters, go to SHIFT.
- State SHIFT:
  - dout_valid = 1 and dout = shreg[N-1].
  - The hold counter counts 0..CLKS_PER_BIT-1. At wrap, the shift register shifts left by one (filling 0) and the bit counter increments.
  - The final cycle is bit counter = N-1 and hold counter = CLKS_PER_BIT-1. In that cycle:
    - dout_last = 1 and din_ready = 1.
    - If a transfer occurs, the new word loads, counters clear and the block stays in SHIFT (no gap).
    - Otherwise the block goes to IDLE and the shift register clears.
- In SHIFT, din_valid outside the final cycle is ignored. The block applies no backpressure to the serial side, which has no ready signal.
- Counter widths: bit counter is clog2(N) bits; hold counter is max(1, clog2(CLKS_PER_BIT)) bits. Neither counter may exceed its terminal value.
- Simultaneous events:
  - rst has priority over everything, including a transfer in the same cycle; that word is dropped.
  - Reset mid-word aborts the frame; no partial dout_last is emitted.
- dout, dout_valid, dout_last and busy are derived from registered state with no combinational path from din_*.

## Timing

- Transfer at edge k: the MSB appears on dout in the cycle after edge k (call it cycle k+1).
- Bit i (MSB = bit N-1) is driven for cycles k+1+(N-1-i)*C through k+(N-i)*C, where C = CLKS_PER_BIT.
- dout_last and din_ready are high in cycle k+N*C only.
- Back-to-back throughput is one word per N*C cycles, with dout_valid continuously high.
- Minimum IDLE gap after a non-back-to-back word: 1 cycle. In that cycle din_ready = 1 and dout_valid = 0.
- Accept latency from IDLE: din_valid high in a cycle gives a transfer at that cycle's edge.

## Test plan

- Reset: rst high 3 cycles with din_valid = 1 and din_data = 0xFF -> din_ready = 0, dout = 0, dout_valid = 0 throughout. The cycle after release -> din_ready = 1 and busy = 0.
- Single word, N = 8, C = 1: transfer 0xA5 at edge k -> dout = 1,0,1,0,0,1,0,1 in cycles k+1..k+8. dout_valid is high for exactly those 8 cycles; dout_last and din_ready are high only in k+8. Cycle k+9 -> dout_valid = 0, din_ready = 1.
- Back-to-back: din_valid held with 0xA5 then 0x3C -> second transfer at edge k+8. Output is 16 contiguous valid bits, 10100101 00111100, with dout_last in k+8 and k+16.
- Hold time, N = 8, C = 3: transfer 0x81 -> 1 for cycles k+1..k+3, 0 for k+4..k+21, 1 for k+22..k+24. dout_last and din_ready are high only in k+24.
- Reset mid-word: rst asserted after 3 bits of 0xF0 -> the next cycle has dout_valid = 0 and no dout_last. After release, transfer 0x0F -> output is 00001111 starting with its MSB.
- Ignored inputs: during SHIFT of 0x5A, toggle din_data every cycle and pulse din_valid in non-final cycles -> output stays 01011010 and no extra transfer occurs.
